// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;
  timeunit 1ns;
  timeprecision 1ps;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;
endpackage

// File: rtl/FS_NP.sv
// One-bit full subtractor built purely from NAND gates, each with a modelled delay.
// Computes d = a ^ b ^ bin and bout = (~a & b) | (~(a ^ b) & bin).
module FS_NP #(
  parameter int unsigned NAND_TIME = 7
) (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  timeunit 1ns;
  timeprecision 1ps;

  logic w_n1, w_n2, w_n3, w_x1;
  logic w_n4, w_n5, w_n6;
  logic w_na, w_nx, w_n7, w_n8;

  // First XOR: a ^ b
  assign #(NAND_TIME) w_n1 = ~(a & b);
  assign #(NAND_TIME) w_n2 = ~(a & w_n1);
  assign #(NAND_TIME) w_n3 = ~(b & w_n1);
  assign #(NAND_TIME) w_x1 = ~(w_n2 & w_n3);

  // Second XOR: (a ^ b) ^ bin
  assign #(NAND_TIME) w_n4 = ~(w_x1 & bin);
  assign #(NAND_TIME) w_n5 = ~(w_x1 & w_n4);
  assign #(NAND_TIME) w_n6 = ~(bin & w_n4);
  assign #(NAND_TIME) d    = ~(w_n5 & w_n6);

  // Borrow as NAND-of-NANDs over the two product terms
  assign #(NAND_TIME) w_na = ~(a & a);
  assign #(NAND_TIME) w_nx = ~(w_x1 & w_x1);
  assign #(NAND_TIME) w_n7 = ~(w_na & b);
  assign #(NAND_TIME) w_n8 = ~(w_nx & bin);
  assign #(NAND_TIME) bout = ~(w_n7 & w_n8);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single NAND subtractor cell.
// Start/done handshake; results stay registered until the next accepted start.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned NAND_TIME = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  sub_state_t      r_state, w_state_next;
  logic [WIDTH-1:0] r_ra, r_rb, r_rdiff;
  logic             r_borrow;
  logic [CntW-1:0]  r_cnt;
  logic             w_accept;
  logic             w_d, w_bout;

  FS_NP #(
    .NAND_TIME (NAND_TIME)
  ) u_cell (
    .a    (r_ra[0]),
    .b    (r_rb[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LastCnt) w_state_next = DONE;
      end
      DONE: begin
        // Back-to-back start is taken here; done still lasts only this cycle
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rdiff  <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ra     <= a;
        r_rb     <= b;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
      end else if (r_state == RUN) begin
        r_rdiff  <= {w_d, r_rdiff[WIDTH-1:1]};
        r_ra     <= {1'b0, r_ra[WIDTH-1:1]};
        r_rb     <= {1'b0, r_rb[WIDTH-1:1]};
        r_borrow <= w_bout;
        r_cnt    <= r_cnt + CntW'(1);
      end
    end
  end

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_rdiff;
  assign borrow_out = r_borrow;
  assign zero       = (r_rdiff == '0);
endmodule
